// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use/branch/MULT-DIV
// stall detection, and a busy tracker for the multi-cycle MULT/DIV unit.
module hazard_unit #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int MULT_LAT      = 4,
  parameter int DIV_LAT       = 32,
  parameter int CNT_WIDTH     = 6
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsE,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegM,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegW,
  input  logic                     i_RegWriteE,
  input  logic                     i_RegWriteM,
  input  logic                     i_RegWriteW,
  input  logic                     i_MemtoRegE,
  input  logic                     i_MemtoRegM,
  input  logic                     i_BranchD,
  input  logic                     i_MDStartD,
  input  logic                     i_MDReadD,
  input  logic                     i_MDStartE,
  input  logic                     i_MDIsDivE,
  input  logic                     i_MDAbort,
  output logic [2:0]               o_ForwardAE,
  output logic [2:0]               o_ForwardBE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_FlushE,
  output logic                     o_MDBusy,
  output logic                     o_MDDone,
  output logic                     o_MDProtoErr
);

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

  localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_LAT - 2);
  localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_LAT - 2);
  localparam logic [RF_ADDR_WIDTH-1:0] REG_ZERO = '0;

  md_state_t              state, next_state;
  logic [CNT_WIDTH-1:0]   cnt, next_cnt;
  logic                   md_done, next_done;
  logic                   proto_err, next_err;

  logic lw_stall, br_stall, md_stall, stall;
  logic e_hits_d, m_hits_d;

  // Execute-stage forwarding: memory stage is newer, so it wins over writeback
  always_comb begin
    o_ForwardAE = 3'd0;
    if (i_RegWriteM && (i_WriteRegM != REG_ZERO) && (i_WriteRegM == i_RsE))
      o_ForwardAE = 3'd2;
    else if (i_RegWriteW && (i_WriteRegW != REG_ZERO) && (i_WriteRegW == i_RsE))
      o_ForwardAE = 3'd1;

    o_ForwardBE = 3'd0;
    if (i_RegWriteM && (i_WriteRegM != REG_ZERO) && (i_WriteRegM == i_RtE))
      o_ForwardBE = 3'd2;
    else if (i_RegWriteW && (i_WriteRegW != REG_ZERO) && (i_WriteRegW == i_RtE))
      o_ForwardBE = 3'd1;
  end

  assign o_ForwardAD = i_RegWriteM && (i_WriteRegM != REG_ZERO) && (i_WriteRegM == i_RsD);
  assign o_ForwardBD = i_RegWriteM && (i_WriteRegM != REG_ZERO) && (i_WriteRegM == i_RtD);

  assign e_hits_d = i_RegWriteE && (i_WriteRegE != REG_ZERO) &&
                    ((i_WriteRegE == i_RsD) || (i_WriteRegE == i_RtD));
  assign m_hits_d = i_MemtoRegM && (i_WriteRegM != REG_ZERO) &&
                    ((i_WriteRegM == i_RsD) || (i_WriteRegM == i_RtD));

  assign lw_stall = i_MemtoRegE && ((i_RtE == i_RsD) || (i_RtE == i_RtD));
  assign br_stall = i_BranchD && (e_hits_d || m_hits_d);
  assign md_stall = (o_MDBusy || i_MDStartE) && (i_MDReadD || i_MDStartD);
  assign stall    = lw_stall || br_stall || md_stall;

  assign o_StallF = stall;
  assign o_StallD = stall;
  assign o_FlushE = stall;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      md_done   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      md_done   <= next_done;
      proto_err <= next_err;
    end
  end

  // A start while busy (including the final busy cycle) never reloads the
  // counter; the running operation simply continues and the error is latched.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = 1'b0;
    next_err   = proto_err;
    case (state)
      MD_IDLE: begin
        if (i_MDAbort) begin
          next_cnt = '0;
        end else if (i_MDStartE) begin
          next_state = MD_BUSY;
          next_cnt   = i_MDIsDivE ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (i_MDAbort) begin
          next_state = MD_IDLE;
          next_cnt   = '0;
        end else begin
          if (i_MDStartE)
            next_err = 1'b1;
          if (cnt == '0) begin
            next_state = MD_IDLE;
            next_done  = 1'b1;
          end else begin
            next_cnt = cnt - 1'b1;
          end
        end
      end
      default: begin
        next_state = MD_IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign o_MDBusy     = (state == MD_BUSY);
  assign o_MDDone     = md_done;
  assign o_MDProtoErr = proto_err;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: forwarding, stalls and the
// MULT/DIV busy tracker including abort, protocol error and async reset.
module tb_hazard_unit;

  logic       i_CLK, i_RST;
  logic [4:0] i_RsD, i_RtD, i_RsE, i_RtE;
  logic [4:0] i_WriteRegE, i_WriteRegM, i_WriteRegW;
  logic       i_RegWriteE, i_RegWriteM, i_RegWriteW;
  logic       i_MemtoRegE, i_MemtoRegM, i_BranchD;
  logic       i_MDStartD, i_MDReadD, i_MDStartE, i_MDIsDivE, i_MDAbort;
  logic [2:0] o_ForwardAE, o_ForwardBE;
  logic       o_ForwardAD, o_ForwardBD, o_StallF, o_StallD, o_FlushE;
  logic       o_MDBusy, o_MDDone, o_MDProtoErr;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  hazard_unit #(
    .RF_ADDR_WIDTH(5), .MULT_LAT(4), .DIV_LAT(32), .CNT_WIDTH(6)
  ) dut (
    .i_CLK(i_CLK), .i_RST(i_RST),
    .i_RsD(i_RsD), .i_RtD(i_RtD), .i_RsE(i_RsE), .i_RtE(i_RtE),
    .i_WriteRegE(i_WriteRegE), .i_WriteRegM(i_WriteRegM), .i_WriteRegW(i_WriteRegW),
    .i_RegWriteE(i_RegWriteE), .i_RegWriteM(i_RegWriteM), .i_RegWriteW(i_RegWriteW),
    .i_MemtoRegE(i_MemtoRegE), .i_MemtoRegM(i_MemtoRegM), .i_BranchD(i_BranchD),
    .i_MDStartD(i_MDStartD), .i_MDReadD(i_MDReadD), .i_MDStartE(i_MDStartE),
    .i_MDIsDivE(i_MDIsDivE), .i_MDAbort(i_MDAbort),
    .o_ForwardAE(o_ForwardAE), .o_ForwardBE(o_ForwardBE),
    .o_ForwardAD(o_ForwardAD), .o_ForwardBD(o_ForwardBD),
    .o_StallF(o_StallF), .o_StallD(o_StallD), .o_FlushE(o_FlushE),
    .o_MDBusy(o_MDBusy), .o_MDDone(o_MDDone), .o_MDProtoErr(o_MDProtoErr)
  );

  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount = checkCount + 1;
    assert (observed === expected) passCount = passCount + 1;
    else begin
      failCount = failCount + 1;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Zero every data/control input so each step starts from a quiet pipeline
  task automatic applyStimulus();
    i_RsD = 0; i_RtD = 0; i_RsE = 0; i_RtE = 0;
    i_WriteRegE = 0; i_WriteRegM = 0; i_WriteRegW = 0;
    i_RegWriteE = 0; i_RegWriteM = 0; i_RegWriteW = 0;
    i_MemtoRegE = 0; i_MemtoRegM = 0; i_BranchD = 0;
    i_MDStartD = 0; i_MDReadD = 0; i_MDStartE = 0; i_MDIsDivE = 0; i_MDAbort = 0;
  endtask

  task automatic nextCycle();
    @(posedge i_CLK);
    #2;
  endtask

  task automatic checkStall(input string tag, input logic expected);
    checkOutput({tag, "_StallF"}, {7'd0, o_StallF}, {7'd0, expected});
    checkOutput({tag, "_StallD"}, {7'd0, o_StallD}, {7'd0, expected});
    checkOutput({tag, "_FlushE"}, {7'd0, o_FlushE}, {7'd0, expected});
  endtask

  task automatic checkMd(input string tag, input logic busy, input logic done);
    checkOutput({tag, "_busy"}, {7'd0, o_MDBusy}, {7'd0, busy});
    checkOutput({tag, "_done"}, {7'd0, o_MDDone}, {7'd0, done});
  endtask

  initial begin
    applyStimulus();
    i_RST = 1'b1;
    #12;
    checkMd("reset", 1'b0, 1'b0);
    checkOutput("reset_protoerr", {7'd0, o_MDProtoErr}, 8'd0);
    checkOutput("reset_fae", {5'd0, o_ForwardAE}, 8'd0);
    checkOutput("reset_fbe", {5'd0, o_ForwardBE}, 8'd0);
    checkStall("reset", 1'b0);
    i_RST = 1'b0;
    nextCycle();

    // Forwarding priority and register-zero exclusion
    i_RegWriteM = 1; i_WriteRegM = 8; i_RegWriteW = 1; i_WriteRegW = 8; i_RsE = 8;
    #1 checkOutput("fwd_mem_wins", {5'd0, o_ForwardAE}, 8'd2);
    i_RegWriteM = 0;
    #1 checkOutput("fwd_wb", {5'd0, o_ForwardAE}, 8'd1);
    i_RsE = 0; i_WriteRegM = 0; i_WriteRegW = 0; i_RegWriteM = 1;
    #1 checkOutput("fwd_reg0", {5'd0, o_ForwardAE}, 8'd0);
    applyStimulus();
    i_RegWriteW = 1; i_WriteRegW = 3; i_RtE = 3;
    #1 checkOutput("fwd_b_wb", {5'd0, o_ForwardBE}, 8'd1);
    checkOutput("fwd_a_idle", {5'd0, o_ForwardAE}, 8'd0);

    // Load-use stall
    applyStimulus();
    i_MemtoRegE = 1; i_RtE = 9; i_RsD = 9;
    #1 checkStall("lw_rs", 1'b1);
    i_RsD = 10; i_RtD = 10;
    #1 checkStall("lw_none", 1'b0);
    i_RtD = 9;
    #1 checkStall("lw_rt", 1'b1);

    // Branch compare hazards and decode forwarding
    applyStimulus();
    i_BranchD = 1; i_RegWriteE = 1; i_WriteRegE = 4; i_RtD = 4;
    #1 checkStall("br_e", 1'b1);
    i_WriteRegE = 0;
    #1 checkStall("br_e_reg0", 1'b0);
    i_RegWriteM = 1; i_WriteRegM = 5; i_RsD = 5;
    #1 checkOutput("fwd_ad", {7'd0, o_ForwardAD}, 8'd1);
    checkOutput("fwd_bd", {7'd0, o_ForwardBD}, 8'd0);
    checkStall("br_fwd", 1'b0);
    i_MemtoRegM = 1;
    #1 checkStall("br_load_m", 1'b1);

    // MULT: busy cycles 1..3, done at cycle 4, MFLO stalls 0..3
    applyStimulus();
    i_MDStartE = 1; i_MDIsDivE = 0; i_MDReadD = 1;
    #1 checkStall("mult_c0", 1'b1);
    checkMd("mult_c0", 1'b0, 1'b0);
    nextCycle();
    i_MDStartE = 0;
    for (int c = 1; c <= 3; c++) begin
      #1 checkMd($sformatf("mult_c%0d", c), 1'b1, 1'b0);
      checkStall($sformatf("mult_c%0d", c), 1'b1);
      nextCycle();
    end
    #1 checkMd("mult_c4", 1'b0, 1'b1);
    checkStall("mult_c4", 1'b0);
    nextCycle();
    checkMd("mult_c5", 1'b0, 1'b0);

    // DIV aborted at cycle 10: no done pulse ever appears
    applyStimulus();
    i_MDStartE = 1; i_MDIsDivE = 1;
    nextCycle();
    i_MDStartE = 0; i_MDIsDivE = 0;
    repeat (9) nextCycle();
    #1 checkMd("div_c10", 1'b1, 1'b0);
    i_MDAbort = 1;
    nextCycle();
    i_MDAbort = 0;
    #1 checkMd("div_abort_c11", 1'b0, 1'b0);
    begin
      logic sawDone = 1'b0;
      for (int c = 0; c < 30; c++) begin
        nextCycle();
        if (o_MDDone || o_MDBusy) sawDone = 1'b1;
      end
      checkOutput("div_abort_quiet", {7'd0, sawDone}, 8'd0);
    end
    checkOutput("protoerr_clear", {7'd0, o_MDProtoErr}, 8'd0);

    // Start while busy latches a sticky protocol error
    i_MDStartE = 1;
    nextCycle();
    #1 checkMd("pe_c1", 1'b1, 1'b0);
    nextCycle();
    i_MDStartE = 0;
    #1 checkOutput("protoerr_set", {7'd0, o_MDProtoErr}, 8'd1);
    repeat (10) nextCycle();
    checkOutput("protoerr_sticky", {7'd0, o_MDProtoErr}, 8'd1);
    checkMd("pe_idle", 1'b0, 1'b0);

    // Asynchronous reset mid-DIV, away from any clock edge
    i_MDStartE = 1; i_MDIsDivE = 1;
    nextCycle();
    i_MDStartE = 0; i_MDIsDivE = 0;
    repeat (5) nextCycle();
    #1 checkMd("div_pre_rst", 1'b1, 1'b0);
    i_RST = 1'b1;
    #1 checkMd("async_rst", 1'b0, 1'b0);
    checkOutput("async_rst_pe", {7'd0, o_MDProtoErr}, 8'd0);
    i_RST = 1'b0;
    nextCycle();

    // MULT after reset runs the normal 4-cycle occupancy
    i_MDStartE = 1;
    nextCycle();
    i_MDStartE = 0;
    for (int c = 1; c <= 3; c++) begin
      #1 checkMd($sformatf("mult2_c%0d", c), 1'b1, 1'b0);
      nextCycle();
    end
    #1 checkMd("mult2_c4", 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
